// File: rtl/rr_mux_scheduler.sv
// rtl/rr_mux_scheduler.sv - round-robin burst scheduler driving a registered one-hot MUX select
module rr_mux_scheduler #(
  parameter int CHANNELS  = 8,
  parameter int MAX_BURST = 16,
  localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CNTW = $clog2(MAX_BURST + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] req,
  input  logic [CHANNELS-1:0] last,
  input  logic                out_ready,
  output logic [CHANNELS-1:0] sel_one_hot,
  output logic [IDXW-1:0]     grant_idx,
  output logic                out_valid,
  output logic                out_last,
  output logic [CHANNELS-1:0] ack
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [IDXW-1:0]     ptr_q, ptr_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [CHANNELS-1:0] sel_q, sel_d;
  logic [IDXW-1:0]     idx_q, idx_d;

  logic                pick_found;
  logic [IDXW-1:0]     pick_idx;
  logic                granted;
  logic                beat;
  logic                release_g;
  logic [IDXW-1:0]     ptr_next;

  // First requester at or after ptr, wrapping around the channel ring.
  always_comb begin
    int c;
    pick_found = 1'b0;
    pick_idx   = '0;
    c          = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      c = (int'(ptr_q) + k) % CHANNELS;
      if (!pick_found && req[c]) begin
        pick_found = 1'b1;
        pick_idx   = IDXW'(c);
      end
    end
  end

  assign granted   = (state_q == ST_GRANT);
  assign out_valid = granted & req[idx_q];
  assign out_last  = granted & last[idx_q];
  assign beat      = out_valid & out_ready;
  assign ack       = beat ? sel_q : '0;

  // A dropped request releases without an ack; a burst limit release resumes the packet later.
  assign release_g = granted & (~req[idx_q]
                               | (beat & last[idx_q])
                               | (beat & (cnt_q == CNTW'(MAX_BURST - 1))));

  assign ptr_next = (idx_q == IDXW'(CHANNELS - 1)) ? '0 : idx_q + IDXW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    if (state_q == ST_IDLE) begin
      if (pick_found) begin
        state_d = ST_GRANT;
        sel_d   = {{(CHANNELS-1){1'b0}}, 1'b1} << pick_idx;
        idx_d   = pick_idx;
        cnt_d   = '0;
      end
    end else begin
      if (beat) begin
        cnt_d = cnt_q + CNTW'(1);
      end
      if (release_g) begin
        state_d = ST_IDLE;
        sel_d   = '0;
        idx_d   = '0;
        ptr_d   = ptr_next;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
    end
  end

  assign sel_one_hot = sel_q;
  assign grant_idx   = idx_q;

endmodule

// File: tb/tb_rr_mux_scheduler.sv
// tb/tb_rr_mux_scheduler.sv - self-checking bench for rr_mux_scheduler with a cycle-level reference model
module tb_rr_mux_scheduler;

  localparam int CH = 8;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] req;
  logic [CH-1:0] last;
  logic          out_ready;
  logic [CH-1:0] sel_one_hot;
  logic [2:0]    grant_idx;
  logic          out_valid;
  logic          out_last;
  logic [CH-1:0] ack;

  int total = 0;
  int bad   = 0;

  // Reference model: granted channel (-1 when idle), search start, accepted beats in this grant.
  int m_gnt = -1;
  int m_ptr = 0;
  int m_cnt = 0;

  rr_mux_scheduler #(.CHANNELS(CH), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .last       (last),
    .out_ready  (out_ready),
    .sel_one_hot(sel_one_hot),
    .grant_idx  (grant_idx),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .ack        (ack)
  );

  always #5 clk = ~clk;

  function automatic logic [CH-1:0] exp_sel();
    logic [CH-1:0] e;
    e = '0;
    if (m_gnt >= 0) e[m_gnt] = 1'b1;
    return e;
  endfunction

  function automatic logic exp_valid();
    return (m_gnt >= 0) ? req[m_gnt] : 1'b0;
  endfunction

  function automatic logic exp_last();
    return (m_gnt >= 0) ? last[m_gnt] : 1'b0;
  endfunction

  function automatic logic [CH-1:0] exp_ack();
    return (exp_valid() && out_ready) ? exp_sel() : '0;
  endfunction

  task automatic model_step();
    int g;
    if (reset) begin
      m_gnt = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_gnt < 0) begin
      for (int k = 0; k < CH; k++) begin
        if (m_gnt < 0 && req[(m_ptr + k) % CH]) begin
          m_gnt = (m_ptr + k) % CH;
          m_cnt = 0;
        end
      end
    end else begin
      g = m_gnt;
      if (!req[g]) begin
        m_gnt = -1; m_ptr = (g + 1) % CH;
      end else if (out_ready) begin
        m_cnt++;
        if (last[g] || m_cnt == MB) begin
          m_gnt = -1; m_ptr = (g + 1) % CH;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; last = '0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      total++;
      if (sel_one_hot !== 8'h00 || out_valid !== 1'b0 || ack !== 8'h00 || grant_idx !== 3'd0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d sel=%h valid=%b ack=%h idx=%0d want all zero",
                 c, sel_one_hot, out_valid, ack, grant_idx);
      end
      tick();
    end
  endtask

  task automatic test_single();
    logic [CH-1:0] want;
    do_reset();
    req = 8'h01; last = 8'h01; out_ready = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      want = (c % 2 == 1) ? 8'h01 : 8'h00;
      total++;
      if (sel_one_hot !== want || ack !== want) begin
        bad++;
        $display("FAIL single_regrant cyc=%0d sel=%h ack=%h want %h", c, sel_one_hot, ack, want);
      end
      tick();
    end
  endtask

  task automatic test_all_requesters();
    logic [CH-1:0] want;
    do_reset();
    req = 8'hFF; last = 8'hFF; out_ready = 1'b1;
    #1;
    for (int c = 0; c < 18; c++) begin
      want = (c % 2 == 1) ? (8'h01 << (((c - 1) / 2) % CH)) : 8'h00;
      total++;
      if (sel_one_hot !== want || ack !== want ||
          (c % 2 == 1 && grant_idx !== 3'(((c - 1) / 2) % CH))) begin
        bad++;
        $display("FAIL rotate_all cyc=%0d sel=%h ack=%h idx=%0d want sel %h", c, sel_one_hot, ack,
                 grant_idx, want);
      end
      tick();
    end
  endtask

  task automatic test_burst_limit();
    int acks0;
    int grants;
    int second;
    logic [CH-1:0] prev;
    do_reset();
    req = 8'h09; last = 8'h00; out_ready = 1'b1;
    #1;
    acks0 = 0; grants = 0; second = -1; prev = '0;
    for (int c = 0; c < 60 && grants < 2; c++) begin
      if (sel_one_hot != 0 && prev == 0) begin
        grants++;
        if (grants == 2) second = int'(grant_idx);
      end
      if (grants == 1 && ack[0]) acks0++;
      prev = sel_one_hot;
      tick();
    end
    total++;
    if (acks0 != MB) begin
      bad++;
      $display("FAIL burst_acks got=%0d want=%0d", acks0, MB);
    end
    total++;
    if (second != 3) begin
      bad++;
      $display("FAIL burst_next_grant got=%0d want=3", second);
    end
  endtask

  task automatic test_stall();
    int acks;
    do_reset();
    req = 8'h04; last = 8'h00; out_ready = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) tick();
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 10; c++) begin
      total++;
      if (sel_one_hot !== 8'h04 || ack !== 8'h00 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d sel=%h ack=%h valid=%b want sel 04 ack 00 valid 1",
                 c, sel_one_hot, ack, out_valid);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    acks = 0;
    for (int c = 0; c < 40 && sel_one_hot != 0; c++) begin
      if (ack[2]) acks++;
      tick();
    end
    total++;
    if (acks != MB - 3) begin
      bad++;
      $display("FAIL stall_count_frozen acks_after=%0d want=%0d", acks, MB - 3);
    end
    tick();
    out_ready = 1'b0;
    #1;
    total++;
    if (sel_one_hot !== 8'h04) begin
      bad++;
      $display("FAIL stall_regrant sel=%h want 04", sel_one_hot);
    end
    req = 8'h00;
    #1;
    total++;
    if (ack !== 8'h00 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL abandon_no_ack ack=%h valid=%b want 00/0", ack, out_valid);
    end
    tick();
    req = 8'hFF; last = 8'hFF;
    #1;
    total++;
    if (sel_one_hot !== 8'h00) begin
      bad++;
      $display("FAIL abandon_release sel=%h want 00", sel_one_hot);
    end
    tick();
    total++;
    if (grant_idx !== 3'd3 || sel_one_hot !== 8'h08) begin
      bad++;
      $display("FAIL abandon_ptr idx=%0d sel=%h want 3/08", grant_idx, sel_one_hot);
    end
  endtask

  task automatic test_reset_mid_burst();
    int acks;
    do_reset();
    req = 8'h20; last = 8'h00; out_ready = 1'b1;
    tick();
    acks = 0;
    for (int c = 0; c < 7; c++) begin
      if (ack[5]) acks++;
      tick();
    end
    total++;
    if (acks != 7 || sel_one_hot !== 8'h20) begin
      bad++;
      $display("FAIL midreset_setup acks=%0d sel=%h want 7/20", acks, sel_one_hot);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; req = 8'hFF;
    #1;
    total++;
    if (sel_one_hot !== 8'h00 || grant_idx !== 3'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_clear sel=%h idx=%0d valid=%b want 00/0/0", sel_one_hot, grant_idx,
               out_valid);
    end
    tick();
    total++;
    if (sel_one_hot !== 8'h01 || grant_idx !== 3'd0) begin
      bad++;
      $display("FAIL midreset_first_grant sel=%h idx=%0d want 01/0", sel_one_hot, grant_idx);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      req       = 8'($urandom) | 8'($urandom);
      last      = 8'($urandom) & 8'($urandom) & 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      total++;
      if (sel_one_hot !== exp_sel() || grant_idx !== 3'((m_gnt < 0) ? 0 : m_gnt) ||
          out_valid !== exp_valid() || out_last !== exp_last() || ack !== exp_ack()) begin
        bad++;
        $display("FAIL random_model cyc=%0d sel=%h idx=%0d v=%b l=%b ack=%h want %h %0d %b %b %h",
                 c, sel_one_hot, grant_idx, out_valid, out_last, ack, exp_sel(),
                 (m_gnt < 0) ? 0 : m_gnt, exp_valid(), exp_last(), exp_ack());
      end
      total++;
      if (!$onehot0(sel_one_hot)) begin
        bad++;
        $display("FAIL random_onehot cyc=%0d sel=%h want one-hot or zero", c, sel_one_hot);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = '0; last = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_all_requesters();
    test_burst_limit();
    test_stall();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
